// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and data (MEM).
// One transaction in flight at a time. Data has priority, but fetch wins once
// data has taken STARVE_MAX consecutive grants while fetch was waiting.
// Sequence per access: IDLE (grant) -> ISSUE (m_en) -> WAIT -> RESP (done).
module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_func3,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);
    localparam logic [3:0] LAT_CNT    = 4'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;     // 1 = data, 0 = fetch
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [2:0]        m_func3_q, m_func3_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              grant_data;
    logic [DATA_W-1:0] cap_data;

    // Data wins unless fetch is waiting and data has used up its streak.
    assign grant_data = d_req && !(if_req && (streak_q == STARVE_CNT));
    // Stores return zero instead of whatever the memory drives.
    assign cap_data   = m_we_q ? '0 : m_rdata;

    // Next-state logic: arbitration, access sequencing and response capture.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        m_en_d     = 1'b0;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_func3_d  = m_func3_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    owner_d   = 1'b1;
                    m_en_d    = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_func3_d = d_func3;
                    if (if_req) begin
                        streak_d = (streak_q == STARVE_CNT) ? STARVE_CNT : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                    state_d = S_ISSUE;
                end else if (if_req) begin
                    owner_d   = 1'b0;
                    m_en_d    = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_func3_d = 3'b000;
                    streak_d  = 4'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_CNT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        d_rdata_d = cap_data;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = cap_data;
                        if_done_d  = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            streak_q   <= 4'd0;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_func3_q  <= 3'b000;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_func3_q  <= m_func3_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_func3  = m_func3_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_stall = if_req & ~if_done_q;
    assign d_stall  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// each grant (memory strobe contents and completion cycle/data); a monitor
// compares whatever the DUT presents against the queued predictions.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_func3;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_func3;
    logic [DATA_W-1:0] m_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_func3(d_func3), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_func3(m_func3), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return ((32'(a) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- memory with fixed read latency ----------------
    logic [31:0] mem [512];
    bit          written [512];
    logic [31:0] pipe [MEM_LAT];

    always @(posedge clk) begin
        if (m_en && m_we) begin
            mem[m_addr]     <= m_wdata;
            written[m_addr] <= 1'b1;
        end
        if (m_en) pipe[0] <= written[m_addr] ? mem[m_addr] : init_val(int'(m_addr));
        else      pipe[0] <= $urandom;   // garbage outside the valid window
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata = pipe[MEM_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [8:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } iss_t;
    typedef struct {
        int          cyc;
        int          owner;
        logic [31:0] rdata;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    bit          act [2];
    bit          granted [2];
    bit          req_v [2];
    bit          allow_new [2];
    int          gap [2];
    int          gap_max [2];
    int          done_at [2];
    logic [8:0]  r_addr [2];
    logic        r_we;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    int          next_arb;
    int          streak;
    logic [31:0] ref_mem [512];
    bit          mon_on = 1'b0;
    bit          exp_if_stall, exp_d_stall;

    task automatic model_reset();
        iss_q.delete();
        rsp_q.delete();
        for (int r = 0; r < 2; r++) begin
            act[r] = 0; granted[r] = 0; req_v[r] = 0; gap[r] = 0; done_at[r] = -10;
        end
        streak   = 0;
        next_arb = 0;
    endtask

    task automatic new_req(input int r);
        act[r]     = 1;
        granted[r] = 0;
        req_v[r]   = 1;
        r_addr[r]  = 9'($urandom_range(0, 15) * 4);
        if (r == 1) begin
            r_we    = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            r_f3    = 3'($urandom_range(0, 7));
        end
    endtask

    // One call per cycle, just after the active edge: update requesters,
    // predict any grant, and drive the inputs for this cycle.
    task automatic step();
        int   c;
        int   owner;
        bit   sc [2];
        iss_t e;
        rsp_t s;
        c = cyc;
        for (int r = 0; r < 2; r++) begin
            if (act[r] && granted[r] && c > done_at[r]) begin
                act[r] = 0; req_v[r] = 0;
                gap[r] = $urandom_range(0, gap_max[r]);
            end
            if (!act[r]) begin
                if (gap[r] == 0 && allow_new[r]) new_req(r);
                else begin
                    req_v[r] = 0;
                    if (gap[r] > 0) gap[r]--;
                end
            end else if (granted[r] && $urandom_range(0, 3) == 0) begin
                req_v[r] = 0;   // dropping req after the grant must not abort
            end
            sc[r] = granted[r];
        end
        owner = -1;
        if (c >= next_arb) begin
            if (req_v[1] && !(req_v[0] && streak == STARVE_MAX)) owner = 1;
            else if (req_v[0]) owner = 0;
        end
        if (owner >= 0) begin
            if (owner == 1) streak = req_v[0] ? ((streak < STARVE_MAX) ? streak + 1 : streak) : 0;
            else            streak = 0;
            e.cyc   = c + 1;
            e.addr  = r_addr[owner];
            e.we    = (owner == 1) ? r_we : 1'b0;
            e.wdata = (owner == 1) ? r_wdata : 32'd0;
            e.f3    = (owner == 1) ? r_f3 : 3'd0;
            s.cyc   = c + MEM_LAT + 2;
            s.owner = owner;
            if (owner == 1 && r_we) begin
                s.rdata = 32'd0;
                ref_mem[r_addr[1]] = r_wdata;
            end else begin
                s.rdata = ref_mem[r_addr[owner]];
            end
            iss_q.push_back(e);
            rsp_q.push_back(s);
            granted[owner] = 1;
            done_at[owner] = s.cyc;
            next_arb       = c + MEM_LAT + 3;
        end
        if_req  = req_v[0];
        if_addr = sc[0] ? 9'($urandom) : r_addr[0];
        d_req   = req_v[1];
        d_addr  = sc[1] ? 9'($urandom) : r_addr[1];
        d_we    = sc[1] ? 1'($urandom) : r_we;
        d_wdata = sc[1] ? $urandom : r_wdata;
        d_func3 = sc[1] ? 3'($urandom) : r_f3;
        exp_if_stall = req_v[0] && !(granted[0] && c == done_at[0]);
        exp_d_stall  = req_v[1] && !(granted[1] && c == done_at[1]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on && !reset) begin
            chk("stalls", {62'd0, if_stall, d_stall}, {62'd0, exp_if_stall, exp_d_stall});
            if (m_en) begin
                if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                    chk("m_addr",  64'(m_addr),  64'(iss_q[0].addr));
                    chk("m_we",    64'(m_we),    64'(iss_q[0].we));
                    chk("m_wdata", 64'(m_wdata), 64'(iss_q[0].wdata));
                    chk("m_func3", 64'(m_func3), 64'(iss_q[0].f3));
                    void'(iss_q.pop_front());
                end else begin
                    chk("unexpected_m_en", 64'd1, 64'd0);
                end
            end
            while (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
                chk("missing_m_en", 64'd0, 64'd1);
                void'(iss_q.pop_front());
            end
            if (if_done || d_done) begin
                chk("single_done", 64'(if_done & d_done), 64'd0);
                if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                    $display("cycle %0d done %s rdata=%08h", cyc, d_done ? "data " : "fetch",
                             d_done ? d_rdata : if_rdata);
                    chk("done_owner", 64'(d_done), 64'(rsp_q[0].owner));
                    chk("rdata", 64'(d_done ? d_rdata : if_rdata), 64'(rsp_q[0].rdata));
                    void'(rsp_q.pop_front());
                end else begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                chk("missing_done", 64'd0, 64'd1);
                void'(rsp_q.pop_front());
            end
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        allow_new[0] = 0;
        allow_new[1] = 0;
        for (int i = 0; i < 60 && !(iss_q.size() == 0 && rsp_q.size() == 0 && cyc >= next_arb); i++) begin
            step();
            @(posedge clk); #1;
        end
        chk("drain", 64'(iss_q.size() + rsp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hits_en, hits_done;
        for (int a = 0; a < 512; a++) ref_mem[a] = init_val(a);
        reset = 1; if_req = 1; d_req = 1; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_func3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_en",     64'(m_en),     64'd0);
        chk("rst_m_we",     64'(m_we),     64'd0);
        chk("rst_m_addr",   64'(m_addr),   64'd0);
        chk("rst_m_wdata",  64'(m_wdata),  64'd0);
        chk("rst_m_func3",  64'(m_func3),  64'd0);
        chk("rst_done",     64'({if_done, d_done}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata",  64'(d_rdata),  64'd0);
        chk("rst_stalls",   64'({if_stall, d_stall}), 64'd3);

        // random traffic on both ports
        model_reset();
        gap_max[0] = 3; gap_max[1] = 3;
        allow_new[0] = 1; allow_new[1] = 1;
        reset  = 0;
        mon_on = 1;
        run(600);
        // both requesters back-to-back: exercises the starvation limit
        gap_max[0] = 0; gap_max[1] = 0;
        run(200);
        drain();

        // reset in the middle of a load: no completion may follow
        mon_on  = 0;
        if_req  = 0;
        d_req   = 1; d_we = 0; d_addr = 9'h040; d_wdata = 32'h0; d_func3 = 3'b010;
        @(posedge clk); #1;
        chk("abort_issue", 64'(m_en), 64'd1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        d_req = 0;
        hits_en = 0; hits_done = 0;
        for (int i = 0; i < 7; i++) begin
            if (m_en) hits_en++;
            if (d_done || if_done) hits_done++;
            @(posedge clk); #1;
        end
        chk("abort_m_en", 64'(hits_en), 64'd0);
        chk("abort_done", 64'(hits_done), 64'd0);

        // a fresh fetch after the abort completes with normal latency
        model_reset();
        mon_on = 1;
        allow_new[0] = 1; allow_new[1] = 0;
        gap_max[0] = 0;
        run(1);
        drain();

        mon_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
